fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
Sequential IEEE-754 single-precision multiplier. It forms the twiddle-factor products that feed the FP adder stage of the Fourier-transform datapath. The mantissa product is computed by an iterative shift-add engine, BPC multiplier bits per cycle. The result is normalized and truncated, with rounding toward zero to match the downstream adder. Valid/ready handshakes are used on both sides.

Parameters:
BPC, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8; iteration count C = 24/BPC
EXP_BIAS, 127, exponent bias

Ports:
g_clk  in  1  clock
n_reset  in  1  reset, asynchronous, active-low
in_valid  in  1  operands present
in_ready  out  1  block can accept operands
op_a  in  32  multiplicand, IEEE-754 single
op_b  in  32  multiplier, IEEE-754 single
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
product  out  32  IEEE-754 single result
overflow  out  1  result saturated to infinity
underflow  out  1  result flushed to zero

Behaviour:
- Reset (async, n_reset low):
  - state = IDLE; product = 0, out_valid = 0, overflow = 0, underflow = 0; internal accumulator and operand registers = 0.
  - in_ready = (state == IDLE), combinational, so it reads 1 during and after reset.
- States and transitions:
  - IDLE: in_ready = 1. On an edge with in_valid && in_ready, capture op_a and op_b, then go to MUL. op_a/op_b may change after capture.
  - MUL: C iterations, one per edge. Each iteration adds ({1,ma} × next BPC bits of {1,mb}, LSB first) into a 48-bit accumulator, then shifts. After the C-th iteration, go to NORM.
  - NORM: one edge. Register product, overflow and underflow; set out_valid = 1; go to DONE.
  - DONE: out_valid = 1; product and flags are held stable. On an edge with out_ready = 1, clear out_valid and go to IDLE.
- No accept in the same cycle as output release; in_ready rises the cycle after the out handshake.
- Latency: out_valid is visible C+1 cycles after the capture edge (BPC = 1 → 25 cycles). With out_ready tied high, one operation completes every C+3 cycles.
- Latency is deterministic: special cases still run all C MUL iterations.
- Arithmetic, with P = 48-bit mantissa product and ea, eb = exponent fields:
  - sign = a[31] ^ b[31]
  - n = P[47]
  - e = ea + eb − EXP_BIAS + n, evaluated in 10-bit signed arithmetic
  - mantissa = n ? P[46:24] : P[45:23]; bits below are truncated, no rounding.
- Special-case priority, evaluated in NORM:
  1. ea == 255 or eb == 255 → {sign, 8'hFF, 23'b0}, overflow = 1. NaN is not propagated.
  2. ea == 0 or eb == 0 → {sign, 31'b0}, both flags 0. Denormals are flushed.
  3. e ≥ 255 → {sign, 8'hFF, 23'b0}, overflow = 1.
  4. e ≤ 0 → {sign, 31'b0}, underflow = 1.
  5. Otherwise → {sign, e[7:0], mantissa}, flags 0.
- Flags are valid only while out_valid = 1. They are re-registered every NORM.
- Reset mid-operation (any state): return to IDLE immediately. The in-flight result is discarded and out_valid drops asynchronously.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Decomposition:
- Shared package fp_pkg:
  - FP_W = 32, EXP_W = 8, MANT_W = 23, EXP_BIAS = 127
  - FP_POS_INF = 32'h7F800000
  - state enum {IDLE, MUL, NORM, DONE}
- One sub-module, fp_mul_pack: combinational. Inputs: 48-bit product, ea, eb, sign. Outputs: packed result, overflow, underflow. It implements all normalization and special-case rules, so it can be unit-checked exhaustively on exponents.

Test Plan:
1. 0x3FC00000 × 0x3FC00000 (1.5 × 1.5), BPC = 1, out_ready = 1 → product 0x40100000 (2.25, normalize path n = 1). out_valid appears exactly 25 cycles after the capture edge; flags 0.
2. 0xC0400000 × 0x3F000000 (−3.0 × 0.5) → 0xBFC00000 (n = 0 path). Repeat with BPC = 2, 4, 8 → same value, latency 13 / 7 / 4.
3. 0x00000000 × 0xC0000000 → 0x80000000, flags 0. Also 0x3F800000 × 0x00400000 (denormal) → 0x00000000.
4. 0x7F000000 × 0x40000000 → 0x7F800000, overflow = 1. Also 0x00800000 × 0x3F000000 → 0x00000000, underflow = 1.
5. out_ready held low for 10 cycles after out_valid → product and flags stable, in_ready = 0, and in_valid pulses are not captured. On out_ready = 1: out_valid drops next cycle and in_ready = 1.
6. Assert n_reset at MUL iteration 5 → out_valid = 0 and in_ready = 1 immediately. After release, 0x40000000 × 0x40400000 → 0x40C00000 (6.0), with correct latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision constants and the sequencer state type for the
// Fourier-transform FP datapath.
package fp_pkg;
  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/fp_mul_pack.sv
// Normalization, truncation and special-case packing of a 48-bit mantissa
// product into an IEEE-754 single result (round toward zero).
module fp_mul_pack
  import fp_pkg::*;
#(
  parameter int EXP_BIAS = 127
) (
  input  logic [47:0]      mant_prod,
  input  logic [EXP_W-1:0] ea,
  input  logic [EXP_W-1:0] eb,
  input  logic             sign,
  output logic [FP_W-1:0]  result,
  output logic             overflow,
  output logic             underflow
);
  localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);

  logic                    n;
  logic signed [9:0]       e;
  logic [MANT_W-1:0]       mant;
  logic                    unused_low;

  assign n          = mant_prod[47];
  assign e          = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S
                      + $signed({9'd0, n});
  assign mant       = n ? mant_prod[46:24] : mant_prod[45:23];
  assign unused_low = ^mant_prod[22:0];

  // Infinity/NaN operands outrank zero/denormal operands; NaN is not propagated.
  always_comb begin
    result    = {sign, 31'd0};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      result   = {sign, FP_POS_INF[30:0]};
      overflow = 1'b1;
    end else if (ea == 8'h00 || eb == 8'h00) begin
      result = {sign, 31'd0};
    end else if (e >= 10'sd255) begin
      result   = {sign, FP_POS_INF[30:0]};
      overflow = 1'b1;
    end else if (e <= 10'sd0) begin
      result    = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      result = {sign, e[7:0], mant};
    end
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: shift-add mantissa engine retiring
// BPC multiplier bits per cycle, with valid/ready handshakes on both sides.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int BPC      = 1,
  parameter int EXP_BIAS = 127
) (
  input  logic            g_clk,
  input  logic            n_reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP_W-1:0] op_a,
  input  logic [FP_W-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] product,
  output logic            overflow,
  output logic            underflow
);
  localparam int C = 24 / BPC;

  state_t            state_reg;
  logic [4:0]        cnt_reg;
  logic [47:0]       mcand_reg;
  logic [23:0]       mplier_reg;
  logic [47:0]       acc_reg;
  logic [47:0]       acc_next;
  logic [EXP_W-1:0]  ea_reg;
  logic [EXP_W-1:0]  eb_reg;
  logic              sign_reg;
  logic [FP_W-1:0]   product_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              out_valid_reg;

  logic [FP_W-1:0]   pack_result;
  logic              pack_overflow;
  logic              pack_underflow;

  logic [47:0]       pp [BPC];

  // One partial product per retired multiplier bit; the multiplicand is
  // pre-shifted each iteration, so bit gi only needs a further gi shift.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_pp
    assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 48'd0;
  end

  always_comb begin
    acc_next = acc_reg;
    for (int i = 0; i < BPC; i++) begin
      acc_next = acc_next + pp[i];
    end
  end

  fp_mul_pack #(
    .EXP_BIAS (EXP_BIAS)
  ) u_pack (
    .mant_prod (acc_reg),
    .ea        (ea_reg),
    .eb        (eb_reg),
    .sign      (sign_reg),
    .result    (pack_result),
    .overflow  (pack_overflow),
    .underflow (pack_underflow)
  );

  always_ff @(posedge g_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      ea_reg        <= '0;
      eb_reg        <= '0;
      sign_reg      <= 1'b0;
      product_reg   <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= {24'd0, 1'b1, op_a[22:0]};
            mplier_reg <= {1'b1, op_b[22:0]};
            ea_reg     <= op_a[30:23];
            eb_reg     <= op_b[30:23];
            sign_reg   <= op_a[31] ^ op_b[31];
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= MUL;
          end
        end
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << BPC;
          mplier_reg <= mplier_reg >> BPC;
          cnt_reg    <= cnt_reg + 5'd1;
          if (cnt_reg == 5'(C - 1)) begin
            state_reg <= NORM;
          end
        end
        NORM: begin
          product_reg   <= pack_result;
          overflow_reg  <= pack_overflow;
          underflow_reg <= pack_underflow;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench: four multipliers (BPC = 1, 2, 4, 8) share one operand
// stream and are compared against an arithmetic reference model.
module tb_fp_mul_seq;
  logic        g_clk;
  logic        n_reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        in_ready_v  [4];
  logic        out_valid_v [4];
  logic [31:0] product_v   [4];
  logic        overflow_v  [4];
  logic        underflow_v [4];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    fp_mul_seq #(
      .BPC      (1 << gi),
      .EXP_BIAS (127)
    ) u_dut (
      .g_clk     (g_clk),
      .n_reset   (n_reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[gi]),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready),
      .product   (product_v[gi]),
      .overflow  (overflow_v[gi]),
      .underflow (underflow_v[gi])
    );
  end

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer mantissa product, then the rounding-toward-zero
  // and special-case rules applied directly.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] p, output logic ov,
                                  output logic uf);
    logic            s;
    int              ea, eb, e, n;
    longint unsigned ma, mb, prod;
    logic [22:0]     m;
    s    = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    ma   = longint'(a[22:0]) + (64'd1 << 23);
    mb   = longint'(b[22:0]) + (64'd1 << 23);
    prod = ma * mb;
    n    = int'((prod >> 47) & 64'd1);
    e    = ea + eb - 127 + n;
    m    = 23'(((n == 1) ? (prod >> 24) : (prod >> 23)) & 64'h7FFFFF);
    ov   = 1'b0;
    uf   = 1'b0;
    if (ea == 255 || eb == 255) begin
      p = {s, 31'h7F800000}; ov = 1'b1;
    end else if (ea == 0 || eb == 0) begin
      p = {s, 31'd0};
    end else if (e >= 255) begin
      p = {s, 31'h7F800000}; ov = 1'b1;
    end else if (e <= 0) begin
      p = {s, 31'd0}; uf = 1'b1;
    end else begin
      p = {s, 8'(e), m};
    end
  endfunction

  // Launch one operation into all four instances with out_ready high and
  // check result, flags, latency and the return to idle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic exp_ov, input logic exp_uf);
    logic [3:0] done;
    done      = 4'h0;
    out_ready = 1'b1;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    for (int cyc = 1; cyc <= 40 && done != 4'hF; cyc++) begin
      @(posedge g_clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (!done[k] && out_valid_v[k]) begin
          done[k] = 1'b1;
          chk($sformatf("%s_lat%0d", tag, k), 32'(cyc), 32'(24 / (1 << k) + 1));
          chk($sformatf("%s_prod%0d", tag, k), product_v[k], exp_p);
          chk($sformatf("%s_ov%0d", tag, k), 32'(overflow_v[k]), 32'(exp_ov));
          chk($sformatf("%s_uf%0d", tag, k), 32'(underflow_v[k]), 32'(exp_uf));
        end
      end
    end
    chk({tag, "_timeout"}, 32'(done), 32'hF);
    @(posedge g_clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_idle%0d", tag, k), {30'd0, in_ready_v[k], out_valid_v[k]}, 32'h2);
    end
    $display("op %-8s %h x %h -> expect %h ov=%0d uf=%0d", tag, a, b, exp_p, exp_ov, exp_uf);
  endtask

  initial begin
    logic [31:0] ra, rb, rp;
    logic        rov, ruf;
    logic [3:0]  seen;

    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    n_reset   = 1'b1;
    #1 n_reset = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_prod%0d", k), product_v[k], 32'h0);
      chk($sformatf("rst_ctl%0d", k),
          {28'd0, in_ready_v[k], out_valid_v[k], overflow_v[k], underflow_v[k]}, 32'h8);
    end
    @(posedge g_clk); @(posedge g_clk); #2;
    n_reset = 1'b1;
    @(posedge g_clk); #1;

    // Directed arithmetic cases
    run_op("norm1",  32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
    run_op("norm0",  32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0);
    run_op("zero",   32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0);
    run_op("denorm", 32'h3F800000, 32'h00400000, 32'h00000000, 1'b0, 1'b0);
    run_op("ovf",    32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
    run_op("unf",    32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1);

    // Backpressure: results held while out_ready is low; in_valid ignored
    out_ready = 1'b0;
    op_a      = 32'h40000000;
    op_b      = 32'h40400000;
    in_valid  = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    seen     = 4'h0;
    for (int cyc = 1; cyc <= 40 && seen != 4'hF; cyc++) begin
      @(posedge g_clk); #1;
      for (int k = 0; k < 4; k++) if (out_valid_v[k]) seen[k] = 1'b1;
    end
    chk("bp_timeout", 32'(seen), 32'hF);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op_a     = $urandom;
      op_b     = $urandom;
      @(posedge g_clk); #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("bp_prod%0d_%0d", k, i), product_v[k], 32'h40C00000);
        chk($sformatf("bp_ctl%0d_%0d", k, i),
            {28'd0, in_ready_v[k], out_valid_v[k], overflow_v[k], underflow_v[k]}, 32'h4);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge g_clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_rel%0d", k), {30'd0, in_ready_v[k], out_valid_v[k]}, 32'h2);
    end
    $display("op %-8s 40000000 x 40400000 held 10 cycles then released", "bp");

    // Reset during MUL iteration 5 (BPC=8 instance is already holding a result)
    out_ready = 1'b0;
    op_a      = 32'h3FC00000;
    op_b      = 32'h3FC00000;
    in_valid  = 1'b1;
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge g_clk);
    #1;
    chk("mid_busy0", 32'(in_ready_v[0]), 32'h0);
    chk("mid_valid3", 32'(out_valid_v[3]), 32'h1);
    n_reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_rst%0d", k), {30'd0, in_ready_v[k], out_valid_v[k]}, 32'h2);
      chk($sformatf("mid_prod%0d", k), product_v[k], 32'h0);
    end
    #1 n_reset = 1'b1;
    $display("op %-8s reset asserted during MUL", "midrst");
    run_op("after", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);

    // Randomized operands against the reference model
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0:       ra[30:23] = 8'($urandom_range(0, 1) * 255);
        1:       begin ra[30:23] = 8'($urandom_range(1, 8)); rb[30:23] = 8'($urandom_range(100, 126)); end
        2:       begin ra[30:23] = 8'($urandom_range(240, 254)); rb[30:23] = 8'($urandom_range(127, 140)); end
        default: begin ra[30:23] = 8'($urandom_range(64, 190)); rb[30:23] = 8'($urandom_range(64, 190)); end
      endcase
      ref_mul(ra, rb, rp, rov, ruf);
      run_op("rand", ra, rb, rp, rov, ruf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
